pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of the program counter and of every stack entry.
REQ-002 Parameter STACK_DEPTH, default 8: number of return-address entries (power of two, >= 2).
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port stall  input  1: when high, all state holds.
REQ-007 Port jmp  input  1: load PC from jmp_addr.
REQ-008 Port cal  input  1: push return address, then load PC from jmp_addr.
REQ-009 Port ret  input  1: pop return address into PC.
REQ-010 Port jmp_addr  input  PC_WIDTH: branch/call target from the decoder.
REQ-011 Port pc  output  PC_WIDTH: registered current instruction address.
REQ-012 Port sp  output  clog2(STACK_DEPTH)+1: registered count of valid stack entries.
REQ-013 Port stack_full / stack_empty  output  1 each: sp == STACK_DEPTH / sp == 0, decoded from the registered sp.
REQ-014 Port stack_overflow / stack_underflow  output  1 each: sticky error flags.

Function
REQ-015 Each cycle the block SHALL take exactly one action, with priority rst > stall > ret > cal > jmp > sequential.
REQ-016 Sequential: pc <= pc + 1 modulo 2^PC_WIDTH; 0xFF wraps to 0x00 at PC_WIDTH 8.
REQ-017 jmp: pc <= jmp_addr; sp unchanged.
REQ-018 cal with sp < STACK_DEPTH: stack[sp] <= pc + 1 (modulo 2^PC_WIDTH), sp <= sp + 1, pc <= jmp_addr, all in the same edge.
REQ-019 cal with stack full: no write, sp unchanged, pc <= jmp_addr, stack_overflow <= 1.
REQ-020 ret with sp > 0: pc <= stack[sp-1], sp <= sp - 1.
REQ-021 ret with stack empty: pc <= pc + 1, sp unchanged, stack_underflow <= 1.
REQ-022 Simultaneous strobes: the lower-priority strobes SHALL be ignored (e.g. ret+cal acts as ret only).
REQ-023 stall high: pc, sp, stack contents and flags all hold, and the strobes are ignored.
REQ-024 Latency: the effect of a strobe SHALL be visible on pc/sp exactly one rising edge after the strobe is sampled; there is no combinational path from inputs to pc or sp.
REQ-025 Call then return SHALL resume at the instruction after the call (return address = call-site pc + 1).

Reset
REQ-026 On rst high at a rising edge: pc <= RESET_PC, sp <= 0, stack_overflow <= 0, stack_underflow <= 0.
REQ-027 Stack storage SHALL NOT be reset; entries at or above sp are don't-care.
REQ-028 Reset asserted mid-call or mid-return sequence SHALL override all strobes and stall in that cycle.

Configuration
REQ-029 Macro PC_STACK_ERR_FLAGS_EN defined: stack_overflow/stack_underflow are implemented as sticky registers per REQ-019/REQ-021, cleared only by rst.
REQ-030 Macro PC_STACK_ERR_FLAGS_EN undefined: both flag outputs are tied to 0 and no flag registers exist; all other behaviour is unchanged, including the no-write on full and no-pop on empty.

Verification (PC_WIDTH=8, STACK_DEPTH=4, RESET_PC=0)
REQ-031 rst for 1 cycle, then 3 idle cycles -> pc = 0x00, 0x01, 0x02, 0x03; sp = 0; stack_empty = 1.
REQ-032 At pc=0x10, cal with jmp_addr=0x40; next edge ret -> pc = 0x40 with sp = 1, then pc = 0x11 with sp = 0.
REQ-033 Five consecutive cal with jmp_addr=0x80 starting at pc=0x00 -> sp saturates at 4, stack_full = 1, stack_overflow = 1 after the fifth; four ret -> pc = 0x81, 0x81, 0x81, 0x01.
REQ-034 ret at pc=0x20 with sp=0 -> pc = 0x21, stack_underflow = 1, and the flag stays 1 until rst.
REQ-035 pc=0xFF, idle -> pc = 0x00; cal at pc=0xFF with jmp_addr=0x05, then ret -> pc = 0x00.
REQ-036 stall held 3 cycles with jmp=1, jmp_addr=0x33 -> pc and sp unchanged; ret+cal asserted together with sp=1 -> pop only, sp = 0.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Control/status bundle between the instruction decoder (master) and the
// program-counter / return-stack unit (slave).
interface pc_stack_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic                stall;
  logic                jmp;
  logic                cal;
  logic                ret;
  logic [PC_WIDTH-1:0] jmp_addr;
  logic [PC_WIDTH-1:0] pc;
  logic [SP_W-1:0]     sp;
  logic                stack_full;
  logic                stack_empty;
  logic                stack_overflow;
  logic                stack_underflow;

  modport master (
    output stall, jmp, cal, ret, jmp_addr,
    input  pc, sp, stack_full, stack_empty, stack_overflow, stack_underflow
  );

  modport slave (
    input  stall, jmp, cal, ret, jmp_addr,
    output pc, sp, stack_full, stack_empty, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack (jump / call / return).
// Optional sticky overflow/underflow flags are built only when PC_STACK_ERR_FLAGS_EN is defined.
module pc_stack_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0
) (
  input  logic            clk,
  input  logic            rst,
  pc_stack_unit_if.slave  bus
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_RET_EMPTY,
    ACT_CAL,
    ACT_CAL_FULL,
    ACT_JMP,
    ACT_SEQ
  } act_e;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [PC_WIDTH-1:0] pop_data_s;
  logic [IDX_W-1:0]    pop_idx_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  act_e                act_s;

  assign pc_inc_s   = pc_q + PC_WIDTH'(1);
  assign full_s     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_s    = (sp_q == SP_W'(0));
  // Top of stack lives one below sp; only read when sp > 0.
  assign pop_idx_s  = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign pop_data_s = stack_q[pop_idx_s];

  // Pick the single action for this cycle by strobe priority.
  always_comb begin
    act_s = ACT_SEQ;
    if (bus.stall) begin
      act_s = ACT_HOLD;
    end else if (bus.ret) begin
      act_s = empty_s ? ACT_RET_EMPTY : ACT_RET;
    end else if (bus.cal) begin
      act_s = full_s ? ACT_CAL_FULL : ACT_CAL;
    end else if (bus.jmp) begin
      act_s = ACT_JMP;
    end else begin
      act_s = ACT_SEQ;
    end
  end

  // Next-state values for pc/sp and the push strobe.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    push_s = 1'b0;
    case (act_s)
      ACT_HOLD: begin
        pc_d = pc_q;
        sp_d = sp_q;
      end
      ACT_RET: begin
        pc_d = pop_data_s;
        sp_d = sp_q - SP_W'(1);
      end
      ACT_RET_EMPTY: pc_d = pc_inc_s;
      ACT_CAL: begin
        push_s = 1'b1;
        pc_d   = bus.jmp_addr;
        sp_d   = sp_q + SP_W'(1);
      end
      ACT_CAL_FULL:  pc_d = bus.jmp_addr;
      ACT_JMP:       pc_d = bus.jmp_addr;
      ACT_SEQ:       pc_d = pc_inc_s;
      default: begin
        pc_d = pc_q;
        sp_d = sp_q;
      end
    endcase
  end

  // PC and stack-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_WIDTH'(RESET_PC);
      sp_q <= SP_W'(0);
    end else begin
      pc_q <= pc_d;
      sp_q <= sp_d;
    end
  end

  // Return-address storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      stack_q[sp_q[IDX_W-1:0]] <= pc_inc_s;
    end
  end

`ifdef PC_STACK_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (act_s == ACT_CAL_FULL);
      udf_q <= udf_q | (act_s == ACT_RET_EMPTY);
    end
  end

  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = udf_q;
`else
  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_full  = full_s;
  assign bus.stack_empty = empty_s;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit (PC_WIDTH=8, STACK_DEPTH=4): a behavioural
// model queues the expected state per cycle, popped and compared after each edge.
module tb_pc_stack_unit;
  localparam int PCW   = 8;
  localparam int DEPTH = 4;
`ifdef PC_STACK_ERR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  logic [7:0] m_pc;
  int         m_sp;
  logic [7:0] m_stack [DEPTH];
  logic       m_ovf;
  logic       m_udf;

  pc_stack_unit_if #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) bus ();

  pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic j, input logic c,
                      input logic rt, input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.stall    = s;
    bus.jmp      = j;
    bus.cal      = c;
    bus.ret      = rt;
    bus.jmp_addr = a;
    if (r) begin
      m_pc = 8'h00; m_sp = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (rt) begin
      if (m_sp > 0) begin
        m_sp = m_sp - 1;
        m_pc = m_stack[m_sp];
      end else begin
        m_pc  = m_pc + 8'd1;
        m_udf = 1'b1;
      end
    end else if (c) begin
      if (m_sp < DEPTH) begin
        m_stack[m_sp] = m_pc + 8'd1;
        m_sp = m_sp + 1;
      end else begin
        m_ovf = 1'b1;
      end
      m_pc = a;
    end else if (j) begin
      m_pc = a;
    end else begin
      m_pc = m_pc + 8'd1;
    end
    e.pc    = m_pc;
    e.sp    = 3'(m_sp);
    e.full  = (m_sp == DEPTH);
    e.empty = (m_sp == 0);
    e.ovf   = FLAGS_EN & m_ovf;
    e.udf   = FLAGS_EN & m_udf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("pc", bus.pc, e.pc);
      check_val("sp", bus.sp, e.sp);
      check_val("full", bus.stack_full, e.full);
      check_val("empty", bus.stack_empty, e.empty);
      check_val("ovf", bus.stack_overflow, e.ovf);
      check_val("udf", bus.stack_underflow, e.udf);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; bus.stall = 1'b0; bus.jmp = 1'b0; bus.cal = 1'b0; bus.ret = 1'b0;
    bus.jmp_addr = 8'h00;
    m_pc = 8'h00; m_sp = 0; m_ovf = 1'b0; m_udf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_stack[i] = 8'h00;

    // Reset then sequential counting
    do_reset();
    check_val("rst_pc", bus.pc, 32'h00);
    check_val("rst_empty", bus.stack_empty, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check_val("seq_pc", bus.pc, 32'(i));
    end

    // Call then immediate return
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
    check_val("cal_pc", bus.pc, 32'h40);
    check_val("cal_sp", bus.sp, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_val("ret_pc", bus.pc, 32'h11);
    check_val("ret_sp", bus.sp, 32'd0);

    // Overflow on fifth call, then unwind
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    check_val("ovf_sp", bus.sp, 32'd4);
    check_val("ovf_full", bus.stack_full, 32'd1);
    check_val("ovf_flag", bus.stack_overflow, 32'(FLAGS_EN));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_val("unwind_pc0", bus.pc, 32'h81);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_val("unwind_pc2", bus.pc, 32'h81);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_val("unwind_pc3", bus.pc, 32'h01);

    // Underflow is sticky until reset
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_val("udf_pc", bus.pc, 32'h21);
    check_val("udf_flag", bus.stack_underflow, 32'(FLAGS_EN));
    idle(); idle();
    check_val("udf_sticky", bus.stack_underflow, 32'(FLAGS_EN));
    do_reset();
    check_val("udf_clr", bus.stack_underflow, 32'd0);

    // PC wrap and call at the top of the address space
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    idle();
    check_val("wrap_pc", bus.pc, 32'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_val("wrap_ret", bus.pc, 32'h00);

    // Stall hold, then ret+cal collapses to ret
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    check_val("stall_pc", bus.pc, 32'h50);
    check_val("stall_sp", bus.sp, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
    check_val("retcal_pc", bus.pc, 32'h01);
    check_val("retcal_sp", bus.sp, 32'd0);

    // Reset beats stall and strobes
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    check_val("rst_prio_pc", bus.pc, 32'h00);
    check_val("rst_prio_sp", bus.sp, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
